// File: rtl/move_select_ctrl.sv
// Player-side move selection: owns the board cursor, validates the picked piece and
// destination against the board/legal-move logic, and hands the move to the board writer.
module move_select_ctrl #(
  parameter int unsigned LEGAL_WAIT = 2,
  parameter bit          RED_FIRST  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         btn_confirm,
  input  logic         btn_cancel,
  input  logic [191:0] serialized_board,
  input  logic [27:0]  legal_move,
  output logic [5:0]   select_loc,
  output logic [5:0]   cursor_loc,
  output logic         turn_red,
  output logic         move_valid,
  input  logic         move_ready,
  output logic [5:0]   move_src,
  output logic [5:0]   move_dst,
  output logic         no_move,
  output logic [1:0]   fsm_state
);

  localparam int unsigned LOC_W  = 6;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned SLOT_W = 7;
  localparam int unsigned SLOTS  = 4;

  typedef enum logic [1:0] {
    PICK  = 2'd0,
    WAIT  = 2'd1,
    DST   = 2'd2,
    ISSUE = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [LOC_W-1:0]   cursor_d, select_d, src_d, dst_d, mv_loc;
  logic               turn_d, valid_d, no_move_d;
  logic [7:0]         sq_base;
  logic               sq_occ, sq_red, any_legal, dst_legal;
  logic [2:0]         cur_x, cur_y;

  assign fsm_state = state;

  // Board square under the cursor and legal-move slot matches.
  always_comb begin
    sq_base   = 8'(cursor_loc) * 8'd3;
    sq_occ    = serialized_board[sq_base + 8'd2];
    sq_red    = serialized_board[sq_base + 8'd1];
    any_legal = 1'b0;
    dst_legal = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      any_legal = any_legal | legal_move[i*SLOT_W + 6];
      if (legal_move[i*SLOT_W + 6] && (legal_move[i*SLOT_W +: LOC_W] == cursor_loc))
        dst_legal = 1'b1;
    end
  end

  // Saturating cursor step for the highest-priority direction button.
  always_comb begin
    cur_x  = cursor_loc[5:3];
    cur_y  = cursor_loc[2:0];
    mv_loc = cursor_loc;
    if (btn_up) begin
      if (cur_y != 3'd7) mv_loc = {cur_x, cur_y + 3'd1};
    end else if (btn_down) begin
      if (cur_y != 3'd0) mv_loc = {cur_x, cur_y - 3'd1};
    end else if (btn_left) begin
      if (cur_x != 3'd0) mv_loc = {cur_x - 3'd1, cur_y};
    end else if (btn_right) begin
      if (cur_x != 3'd7) mv_loc = {cur_x + 3'd1, cur_y};
    end
  end

  // Next-state and next-output logic; cancel and confirm outrank cursor moves.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    cursor_d  = cursor_loc;
    select_d  = select_loc;
    src_d     = move_src;
    dst_d     = move_dst;
    turn_d    = turn_red;
    valid_d   = move_valid;
    no_move_d = 1'b0;
    unique case (state)
      PICK: begin
        if (btn_cancel) begin
          cursor_d = cursor_loc;
        end else if (btn_confirm) begin
          if (sq_occ && (sq_red == turn_red)) begin
            src_d   = cursor_loc;
            cnt_d   = '0;
            state_d = WAIT;
          end
        end else begin
          cursor_d = mv_loc;
        end
        select_d = cursor_d;
      end
      WAIT: begin
        cnt_d = cnt + CNT_W'(1);
        if (cnt == CNT_W'(LEGAL_WAIT - 1)) begin
          if (any_legal) begin
            state_d = DST;
          end else begin
            no_move_d = 1'b1;
            state_d   = PICK;
          end
        end
      end
      DST: begin
        if (btn_cancel) begin
          state_d = PICK;
        end else if (btn_confirm) begin
          if (dst_legal) begin
            dst_d   = cursor_loc;
            valid_d = 1'b1;
            state_d = ISSUE;
          end
        end else begin
          cursor_d = mv_loc;
        end
      end
      ISSUE: begin
        if (move_valid && move_ready) begin
          valid_d = 1'b0;
          turn_d  = ~turn_red;
          state_d = PICK;
        end
      end
      default: state_d = PICK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= PICK;
      cnt        <= '0;
      cursor_loc <= '0;
      select_loc <= '0;
      move_src   <= '0;
      move_dst   <= '0;
      turn_red   <= RED_FIRST;
      move_valid <= 1'b0;
      no_move    <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      cursor_loc <= cursor_d;
      select_loc <= select_d;
      move_src   <= src_d;
      move_dst   <= dst_d;
      turn_red   <= turn_d;
      move_valid <= valid_d;
      no_move    <= no_move_d;
    end
  end

endmodule

// File: tb/tb_move_select_ctrl.sv
// Scoreboard bench for move_select_ctrl: directed scenarios then random play,
// checked against a game-level reference model of the selection rules.
module tb_move_select_ctrl;

  localparam int unsigned LW = 2;
  localparam bit          RF = 1'b1;

  localparam int P_PICK = 0, P_WAIT = 1, P_DST = 2, P_ISSUE = 3;
  localparam logic [5:0] B_NONE   = 6'b000000;
  localparam logic [5:0] B_CANCEL = 6'b100000;
  localparam logic [5:0] B_CONF   = 6'b010000;
  localparam logic [5:0] B_UP     = 6'b001000;
  localparam logic [5:0] B_DOWN   = 6'b000100;
  localparam logic [5:0] B_LEFT   = 6'b000010;
  localparam logic [5:0] B_RIGHT  = 6'b000001;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic         btn_confirm = 1'b0, btn_cancel = 1'b0;
  logic [191:0] serialized_board = '0;
  logic [27:0]  legal_move = '0;
  logic [5:0]   select_loc, cursor_loc, move_src, move_dst;
  logic         turn_red, move_valid, no_move;
  logic         move_ready = 1'b0;
  logic [1:0]   fsm_state;

  always #5 clk = ~clk;

  move_select_ctrl #(.LEGAL_WAIT(LW), .RED_FIRST(RF)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_confirm(btn_confirm), .btn_cancel(btn_cancel),
    .serialized_board(serialized_board), .legal_move(legal_move),
    .select_loc(select_loc), .cursor_loc(cursor_loc), .turn_red(turn_red),
    .move_valid(move_valid), .move_ready(move_ready),
    .move_src(move_src), .move_dst(move_dst), .no_move(no_move), .fsm_state(fsm_state)
  );

  typedef struct {
    int state; int cursor; int sel; bit sel_chk;
    int src; int dst; int turn; int valid; int no_move;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0, n_fail = 0;

  logic [2:0] board [64];
  bit         lv [4];
  int         lx [4], ly [4];

  // Reference model: cursor as (x,y), squares as x*8+y, WAIT as a countdown.
  int m_phase, m_x, m_y, m_src, m_dst, m_turn, m_valid, m_nomove, m_left;

  function automatic int clamp7(int v);
    return (v < 0) ? 0 : ((v > 7) ? 7 : v);
  endfunction

  function automatic bit legal_has(int x, int y);
    for (int i = 0; i < 4; i++)
      if (lv[i] && lx[i] == x && ly[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_legal();
    for (int i = 0; i < 4; i++)
      if (lv[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void apply_move(int act);
    case (act)
      3: m_y = clamp7(m_y + 1);
      2: m_y = clamp7(m_y - 1);
      1: m_x = clamp7(m_x - 1);
      0: m_x = clamp7(m_x + 1);
      default: ;
    endcase
  endfunction

  function automatic void model_step(logic [5:0] b, logic rdy, logic r);
    int act = -1;
    int here;
    for (int i = 5; i >= 0; i--)
      if (b[i] && act < 0) act = i;
    if (!r) begin
      m_phase = P_PICK; m_x = 0; m_y = 0; m_src = 0; m_dst = 0;
      m_turn = int'(RF); m_valid = 0; m_nomove = 0; m_left = 0;
      return;
    end
    m_nomove = 0;
    here = m_x * 8 + m_y;
    case (m_phase)
      P_PICK: begin
        if (act == 4) begin
          if (board[here][2] && (int'(board[here][1]) == m_turn)) begin
            m_src = here; m_phase = P_WAIT; m_left = LW;
          end
        end else apply_move(act);
      end
      P_WAIT: begin
        m_left--;
        if (m_left == 0) begin
          if (any_legal()) m_phase = P_DST;
          else begin m_phase = P_PICK; m_nomove = 1; end
        end
      end
      P_DST: begin
        if (act == 5) m_phase = P_PICK;
        else if (act == 4) begin
          if (legal_has(m_x, m_y)) begin
            m_dst = here; m_valid = 1; m_phase = P_ISSUE;
          end
        end else apply_move(act);
      end
      default: begin
        if (rdy) begin m_valid = 0; m_turn = 1 - m_turn; m_phase = P_PICK; end
      end
    endcase
  endfunction

  task automatic step(input logic [5:0] b, input logic rdy, input logic r);
    exp_t e;
    @(negedge clk);
    {btn_cancel, btn_confirm, btn_up, btn_down, btn_left, btn_right} = b;
    move_ready = rdy;
    rst = r;
    for (int i = 0; i < 64; i++) serialized_board[i*3 +: 3] = board[i];
    for (int i = 0; i < 4; i++) legal_move[i*7 +: 7] = {lv[i], 3'(lx[i]), 3'(ly[i])};
    model_step(b, rdy, r);
    e.state = m_phase; e.cursor = m_x * 8 + m_y; e.sel = m_src;
    e.sel_chk = (!r) || (m_phase != P_PICK);
    e.src = m_src; e.dst = m_dst; e.turn = m_turn; e.valid = m_valid; e.no_move = m_nomove;
    exp_q.push_back(e);
  endtask

  function automatic void chk(string nm, int act, int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
    end
  endfunction

  // Monitor: one expectation per clock, sampled just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("fsm_state", int'(fsm_state), e.state);
      chk("cursor_loc", int'(cursor_loc), e.cursor);
      chk("move_src", int'(move_src), e.src);
      chk("move_dst", int'(move_dst), e.dst);
      chk("turn_red", int'(turn_red), e.turn);
      chk("move_valid", int'(move_valid), e.valid);
      chk("no_move", int'(no_move), e.no_move);
      if (e.sel_chk) chk("select_loc", int'(select_loc), e.sel);
    end
  end

  task automatic set_legal_plan();
    for (int i = 0; i < 4; i++) begin lv[i] = 1'b0; lx[i] = 0; ly[i] = 0; end
    lv[0] = 1'b1; lx[0] = 5; ly[0] = 3;
    lv[1] = 1'b1; lx[1] = 7; ly[1] = 3;
  endtask

  task automatic clear_legal();
    for (int i = 0; i < 4; i++) begin lv[i] = 1'b0; lx[i] = 0; ly[i] = 0; end
  endtask

  task automatic rand_world();
    for (int i = 0; i < 64; i++)
      board[i] = ($urandom_range(0, 1) == 0) ? 3'b000 : {1'b1, 2'($urandom_range(0, 3))};
    for (int i = 0; i < 4; i++) begin
      lv[i] = ($urandom_range(0, 2) != 0);
      lx[i] = clamp7(m_x + int'($urandom_range(0, 2)) - 1);
      ly[i] = clamp7(m_y + int'($urandom_range(0, 2)) - 1);
    end
  endtask

  initial begin
    logic [5:0] b;
    int k;
    for (int i = 0; i < 64; i++) board[i] = 3'b000;
    clear_legal();
    model_step(B_NONE, 1'b0, 1'b0);

    step(B_NONE, 1'b0, 1'b0);
    step(B_NONE, 1'b0, 1'b0);
    step(B_NONE, 1'b0, 1'b1);
    repeat (3) step(B_DOWN, 1'b0, 1'b1);
    repeat (3) step(B_LEFT, 1'b0, 1'b1);
    repeat (9) step(B_RIGHT, 1'b0, 1'b1);

    board[50] = 3'b110;
    board[9]  = 3'b100;
    set_legal_plan();
    step(B_LEFT, 1'b0, 1'b1);
    step(B_UP, 1'b0, 1'b1);
    step(B_UP, 1'b0, 1'b1);
    step(B_CONF, 1'b0, 1'b1);
    step(B_NONE, 1'b0, 1'b1);
    step(B_NONE, 1'b0, 1'b1);
    step(B_LEFT, 1'b0, 1'b1);
    step(B_UP, 1'b0, 1'b1);
    step(B_CONF, 1'b0, 1'b1);
    step(B_CANCEL, 1'b0, 1'b1);
    step(B_UP, 1'b0, 1'b1);
    step(B_CONF, 1'b0, 1'b1);
    step(B_NONE, 1'b1, 1'b1);
    step(B_NONE, 1'b1, 1'b1);

    step(B_NONE, 1'b0, 1'b0);
    step(B_CONF, 1'b0, 1'b1);
    step(B_RIGHT, 1'b0, 1'b1);
    step(B_UP, 1'b0, 1'b1);
    step(B_CONF, 1'b0, 1'b1);

    clear_legal();
    repeat (5) step(B_RIGHT, 1'b0, 1'b1);
    step(B_UP, 1'b0, 1'b1);
    step(B_CONF, 1'b0, 1'b1);
    step(B_NONE, 1'b0, 1'b1);
    step(B_NONE, 1'b0, 1'b1);
    step(B_NONE, 1'b0, 1'b1);

    set_legal_plan();
    step(B_CONF, 1'b0, 1'b1);
    step(B_NONE, 1'b0, 1'b1);
    step(B_NONE, 1'b0, 1'b1);
    step(B_CONF, 1'b0, 1'b1);
    step(B_CANCEL | B_CONF, 1'b0, 1'b1);
    step(B_CONF, 1'b0, 1'b1);
    step(B_NONE, 1'b0, 1'b1);
    step(B_NONE, 1'b0, 1'b1);
    step(B_LEFT, 1'b0, 1'b1);
    step(B_UP, 1'b0, 1'b1);
    step(B_CONF, 1'b0, 1'b1);
    step(B_NONE, 1'b0, 1'b0);
    step(B_NONE, 1'b0, 1'b1);

    // Random play with occasional board/legal refresh and rare resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) rand_world();
      k = int'($urandom_range(0, 11));
      if (k < 6) b = 6'(1 << k);
      else if (k == 6) b = 6'($urandom_range(0, 63));
      else if (k == 7) b = B_CONF;
      else b = B_NONE;
      step(b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 499) != 0));
    end

    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/move_select_ctrl.md
Name: move_select_ctrl

Overview:
- Player-side controller for the board/legal-move logic.
- Owns the on-board cursor and drives `select_loc` into the board logic. It reads back `serialized_board` and `legal_move`, and validates the player's pick and destination against them.
- Issues a source/destination move command to the board writer through a valid/ready handshake, then toggles the turn.
- Sits between the debounced button front end and the board logic.

Parameters:
- `LEGAL_WAIT`, 2, number of cycles spent in WAIT after `select_loc` is frozen, before `legal_move` is trusted. Range 1..7.
- `RED_FIRST`, 1, reset value of `turn_red`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, active-low.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: single-cycle debounced cursor pulses.
- `btn_confirm` in 1: single-cycle pulse.
- `btn_cancel` in 1: single-cycle pulse.
- `serialized_board` in 192: square loc={x,y} occupies bits [loc*3+2:loc*3], encoded {occupied, red, king}.
- `legal_move` in 28: four 7-bit slots at [6:0], [13:7], [20:14], [27:21]; each slot is {valid, x[2:0], y[2:0]}.
- `select_loc` out 6: square queried in the board logic.
- `cursor_loc` out 6: current cursor {x,y}.
- `turn_red` out 1: 1 when it is red's turn.
- `move_valid` out 1: move command valid.
- `move_ready` in 1: board writer accepts the command.
- `move_src` out 6: source square {x,y}.
- `move_dst` out 6: destination square {x,y}.
- `no_move` out 1: one-cycle pulse when the picked piece has no legal move.
- `fsm_state` out 2: PICK=0, WAIT=1, DST=2, ISSUE=3.

Behaviour:
- Reset (`rst`=0 sampled at posedge `clk`):
  - `cursor_loc`=0, `select_loc`=0, `move_src`=0, `move_dst`=0.
  - `move_valid`=0, `no_move`=0, `turn_red`=`RED_FIRST`, state=PICK, wait counter=0.
  - Reset mid-ISSUE drops `move_valid` at that edge; no turn toggle.
- Button priority, one action per cycle: cancel > confirm > up > down > left > right.
- Cursor movement:
  - up: y+1; down: y-1; right: x+1; left: x-1.
  - Saturates at 0 and 7; no wrap.
  - Honoured only in PICK and DST; ignored in WAIT and ISSUE.
- All outputs are registered and update one cycle after the causing pulse.
- PICK:
  - `select_loc` follows `cursor_loc` every cycle, for preview.
  - confirm is accepted only if square[cursor] has occupied=1 and red==`turn_red`.
    - Accepted: `select_loc`<=cursor, `move_src`<=cursor, counter<=0, go to WAIT.
    - Rejected: confirm ignored; stay in PICK.
  - cancel in PICK: no effect.
- WAIT:
  - `select_loc` frozen; counter increments each cycle.
  - When counter==`LEGAL_WAIT`-1, sample the valid bits of all four `legal_move` slots.
    - Any valid bit set: go to DST.
    - None set: `no_move` pulses 1 cycle; go to PICK.
- DST:
  - `select_loc` remains frozen; `legal_move` is re-read live every cycle.
  - confirm is accepted if any slot has valid=1 and slot[5:0]==`cursor_loc`.
    - Accepted: `move_dst`<=cursor, `move_valid`<=1, go to ISSUE.
    - Otherwise: confirm ignored.
  - cancel: go to PICK; cursor unchanged.
- ISSUE:
  - `move_valid`=1; `move_src` and `move_dst` stable until `move_ready`=1 is sampled.
  - On that edge: `move_valid`<=0, `turn_red` toggles, go to PICK; cursor stays at dst.
  - Buttons ignored, including cancel.
  - `move_ready` while `move_valid`=0 is ignored in every state.
- Turn toggles only on handshake completion.
- Jump moves, multi-jump and king promotion are outside this block.

Test Plan:
- Reset with `RED_FIRST`=1 -> `cursor_loc`=0, `fsm_state`=0, `turn_red`=1, `move_valid`=0; press down and left 3 times each -> `cursor_loc` stays 0. Press right 9 times -> x=7 (`cursor_loc`=56).
- Board: red pawn at {6,2} (=50, 3'b110), white at {1,1}; `turn_red`=1.
  - Cursor to 50, confirm -> `fsm_state`=1, `select_loc`=50, `move_src`=50.
  - Drive `legal_move`[6:0]=7'b1_101_011 and [13:7]=7'b1_111_011 -> `fsm_state`=2 after `LEGAL_WAIT` cycles.
- Continue: left, up (cursor=43), confirm -> `move_valid`=1, `move_src`=50, `move_dst`=43.
  - Hold `move_ready`=0 for 3 cycles -> outputs stable, buttons ignored.
  - `move_ready`=1 -> `move_valid`=0, `turn_red`=0, `fsm_state`=0.
- `turn_red`=1, cursor on white {1,1} (=9), confirm -> stays PICK. Cursor on empty {0,0}, confirm -> stays PICK.
- Red selected with `legal_move`=0 -> `no_move` high exactly 1 cycle, return to PICK.
- In DST, confirm on a non-legal square (cursor=50) -> stays DST. confirm+cancel in the same cycle -> PICK. Assert `rst`=0 during ISSUE -> `move_valid`=0 next edge, `turn_red`=`RED_FIRST`.
